// File: rtl/hazard_ctrl.sv
// Hazard and stall scheduler for the RISC-RNS pipeline: detects load-use
// hazards, sequences multi-cycle RNS ops through a start/done handshake,
// squashes the ID instruction on taken branches and counts stall cycles.
module hazard_ctrl #(
  parameter int LOAD_LAT   = 1,
  parameter int MC_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  op1_addr_ID,
  input  logic [2:0]  op2_addr_ID,
  input  logic [2:0]  op3_addr_ID,
  input  logic [2:0]  op_used_ID,
  input  logic        mc_op_ID,
  input  logic        load_true_EX,
  input  logic        reg_wr_en_EX,
  input  logic [2:0]  dest_addr_EX,
  input  logic        branch_taken_EX,
  input  logic        mc_done,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        mc_start,
  output logic        mc_error,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MC_WAIT    = 2'd2
  } state_t;

  // The RUN cycle that detects the hazard is the first stall cycle, so the
  // LOAD_STALL countdown covers the remaining LOAD_LAT-1 cycles.
  localparam logic [7:0] LOAD_CNT_INIT = 8'(LOAD_LAT - 1);
  localparam logic [7:0] MC_LAST       = 8'(MC_TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [15:0] stall_reg, stall_next;

  logic [2:0]  op_addr [3];
  logic [2:0]  op_match;
  logic        hazard;

  assign op_addr[0] = op1_addr_ID;
  assign op_addr[1] = op2_addr_ID;
  assign op_addr[2] = op3_addr_ID;

  // An operand only matters if the ID instruction really reads it.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_match
      assign op_match[gi] = op_used_ID[gi] && (op_addr[gi] == dest_addr_EX);
    end
  endgenerate

  assign hazard = load_true_EX & reg_wr_en_EX & (|op_match);

  // Next-state, counter and pipeline-control outputs.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    mc_start    = 1'b0;
    mc_error    = 1'b0;

    case (state_reg)
      RUN: begin
        if (branch_taken_EX) begin
          // ID instruction is squashed, so its hazards are irrelevant.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (hazard) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          if (LOAD_LAT > 1) begin
            cnt_next   = LOAD_CNT_INIT;
            state_next = LOAD_STALL;
          end
        end else if (mc_op_ID) begin
          mc_start    = 1'b1;
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          cnt_next    = '0;
          state_next  = MC_WAIT;
        end
      end

      LOAD_STALL: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
        cnt_next    = cnt_reg - 8'd1;
        if (cnt_reg <= 8'd1) begin
          cnt_next   = '0;
          state_next = RUN;
        end
      end

      MC_WAIT: begin
        if (mc_done) begin
          // Release: the held multi-cycle instruction moves on to EX.
          cnt_next   = '0;
          state_next = RUN;
        end else if (cnt_reg >= MC_LAST) begin
          mc_error   = 1'b1;
          cnt_next   = '0;
          state_next = RUN;
        end else begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          cnt_next    = cnt_reg + 8'd1;
        end
      end

      default: begin
        cnt_next   = '0;
        state_next = RUN;
      end
    endcase

    // While in reset the pipeline is frozen with a bubble in EX.
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b0;
      mc_start    = 1'b0;
      mc_error    = 1'b0;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_comb begin
    stall_next = stall_reg;
    if (!pc_en && (stall_reg != 16'hFFFF)) begin
      stall_next = stall_reg + 16'd1;
    end
  end

  // State, counter and stall statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
      stall_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      stall_reg <= stall_next;
    end
  end

  assign state        = state_reg;
  assign stall_cycles = stall_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a cycle-level behavioural model of the
// stall rules is compared against the DUT every cycle, and directed scenarios
// pin specific cycles to hand-computed values.
module tb_hazard_ctrl;

  localparam int LL = 3;
  localparam int MT = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  op1_addr_ID, op2_addr_ID, op3_addr_ID, op_used_ID;
  logic        mc_op_ID, load_true_EX, reg_wr_en_EX;
  logic [2:0]  dest_addr_EX;
  logic        branch_taken_EX, mc_done;
  logic        pc_en, ifid_en, ifid_flush, idex_bubble, mc_start, mc_error;
  logic [1:0]  state;
  logic [15:0] stall_cycles;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_LAT(LL), .MC_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst),
    .op1_addr_ID(op1_addr_ID), .op2_addr_ID(op2_addr_ID), .op3_addr_ID(op3_addr_ID),
    .op_used_ID(op_used_ID), .mc_op_ID(mc_op_ID), .load_true_EX(load_true_EX),
    .reg_wr_en_EX(reg_wr_en_EX), .dest_addr_EX(dest_addr_EX),
    .branch_taken_EX(branch_taken_EX), .mc_done(mc_done),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .mc_start(mc_start), .mc_error(mc_error), .state(state), .stall_cycles(stall_cycles)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Stalls are tracked as "cycles still owed" rather than as FSM states.
  int m_load_left = 0;
  bit m_mc        = 1'b0;
  int m_mc_waited = 0;
  int m_stalls    = 0;

  function automatic bit ref_hazard();
    logic [2:0] a [3];
    a[0] = op1_addr_ID;
    a[1] = op2_addr_ID;
    a[2] = op3_addr_ID;
    if (!(load_true_EX && reg_wr_en_EX)) return 1'b0;
    for (int i = 0; i < 3; i++)
      if (op_used_ID[i] && a[i] == dest_addr_EX) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin : model
    bit e_pc, e_ifid, e_flush, e_bub, e_start, e_err;
    int e_state;
    e_pc = 1; e_ifid = 1; e_flush = 0; e_bub = 0; e_start = 0; e_err = 0;
    e_state = (m_load_left > 0) ? 1 : (m_mc ? 2 : 0);
    check("m_state", state, e_state);
    check("m_stall_cycles", stall_cycles, m_stalls);
    if (rst) begin
      e_pc = 0; e_ifid = 0; e_bub = 1;
      m_load_left = 0; m_mc = 0; m_mc_waited = 0; m_stalls = 0;
    end else begin
      if (m_load_left > 0) begin
        e_pc = 0; e_ifid = 0; e_bub = 1;
        m_load_left--;
      end else if (m_mc) begin
        m_mc_waited++;
        if (mc_done) m_mc = 0;
        else if (m_mc_waited == MT) begin m_mc = 0; e_err = 1; end
        else begin e_pc = 0; e_ifid = 0; e_bub = 1; end
      end else if (branch_taken_EX) begin
        e_flush = 1; e_bub = 1;
      end else if (ref_hazard()) begin
        e_pc = 0; e_ifid = 0; e_bub = 1;
        m_load_left = LL - 1;
      end else if (mc_op_ID) begin
        e_start = 1; e_pc = 0; e_ifid = 0; e_bub = 1;
        m_mc = 1; m_mc_waited = 0;
      end
      if (!e_pc && m_stalls < 65535) m_stalls++;
    end
    check("m_pc_en", pc_en, e_pc);
    check("m_ifid_en", ifid_en, e_ifid);
    check("m_ifid_flush", ifid_flush, e_flush);
    check("m_idex_bubble", idex_bubble, e_bub);
    check("m_mc_start", mc_start, e_start);
    check("m_mc_error", mc_error, e_err);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    op1_addr_ID = 0; op2_addr_ID = 0; op3_addr_ID = 0; op_used_ID = 0;
    mc_op_ID = 0; load_true_EX = 0; reg_wr_en_EX = 0; dest_addr_EX = 0;
    branch_taken_EX = 0; mc_done = 0;
  endtask

  task automatic set_load_use();
    load_true_EX = 1; reg_wr_en_EX = 1; dest_addr_EX = 3'd2;
    op1_addr_ID = 3'd2; op_used_ID = 3'b001;
  endtask

  task automatic do_reset();
    cyc(); rst = 1;
    cyc(); rst = 0;
  endtask

  typedef struct {
    logic [2:0] a1, a2, a3, used;
    logic       ld, wr;
    logic [2:0] dst;
    logic       stall;
  } vec_t;
  vec_t vecs [6];

  initial begin
    vecs[0] = '{3'd2, 3'd2, 3'd2, 3'b000, 1'b1, 1'b1, 3'd2, 1'b0};
    vecs[1] = '{3'd5, 3'd3, 3'd7, 3'b100, 1'b1, 1'b1, 3'd7, 1'b1};
    vecs[2] = '{3'd5, 3'd3, 3'd7, 3'b010, 1'b1, 1'b1, 3'd3, 1'b1};
    vecs[3] = '{3'd5, 3'd3, 3'd7, 3'b111, 1'b1, 1'b1, 3'd4, 1'b0};
    vecs[4] = '{3'd2, 3'd2, 3'd2, 3'b111, 1'b0, 1'b1, 3'd2, 1'b0};
    vecs[5] = '{3'd2, 3'd2, 3'd2, 3'b111, 1'b1, 1'b0, 3'd2, 1'b0};

    rst = 1;
    clear_all();
    cyc(); cyc();
    @(negedge clk);
    check("rst_pc_en", pc_en, 0);
    check("rst_idex_bubble", idex_bubble, 1);
    cyc(); rst = 0;
    @(negedge clk);
    check("reset_state", state, 0);
    check("reset_stall_cycles", stall_cycles, 0);
    check("reset_pc_en", pc_en, 1);
    check("reset_ifid_en", ifid_en, 1);
    check("reset_idex_bubble", idex_bubble, 0);

    // Load-use, LOAD_LAT=3; branch/mc_done during the stall are ignored.
    cyc(); set_load_use();
    @(negedge clk);
    check("lu_c0_pc_en", pc_en, 0);
    check("lu_c0_state", state, 0);
    cyc(); clear_all(); mc_done = 1; branch_taken_EX = 1;
    @(negedge clk);
    check("lu_c1_state", state, 1);
    check("lu_c1_pc_en", pc_en, 0);
    check("lu_c1_ifid_flush", ifid_flush, 0);
    cyc(); clear_all();
    @(negedge clk);
    check("lu_c2_state", state, 1);
    check("lu_c2_pc_en", pc_en, 0);
    cyc();
    @(negedge clk);
    check("lu_c3_state", state, 0);
    check("lu_c3_pc_en", pc_en, 1);
    check("lu_stall_cycles", stall_cycles, 3);

    // Operand-usage / write-enable vectors.
    for (int v = 0; v < 6; v++) begin
      cyc();
      op1_addr_ID = vecs[v].a1; op2_addr_ID = vecs[v].a2; op3_addr_ID = vecs[v].a3;
      op_used_ID = vecs[v].used; load_true_EX = vecs[v].ld; reg_wr_en_EX = vecs[v].wr;
      dest_addr_EX = vecs[v].dst;
      @(negedge clk);
      check($sformatf("vec%0d_pc_en", v), pc_en, !vecs[v].stall);
      cyc(); clear_all();
      repeat (3) cyc();
    end

    // Branch together with hazard and mc_op: flush wins, no stall.
    cyc(); set_load_use(); branch_taken_EX = 1; mc_op_ID = 1;
    @(negedge clk);
    check("br_ifid_flush", ifid_flush, 1);
    check("br_idex_bubble", idex_bubble, 1);
    check("br_pc_en", pc_en, 1);
    check("br_mc_start", mc_start, 0);
    cyc(); clear_all();
    @(negedge clk);
    check("br_next_state", state, 0);

    // Multi-cycle op, mc_done 4 cycles after mc_start.
    do_reset();
    cyc(); mc_op_ID = 1;
    @(negedge clk);
    check("mc_start_pulse", mc_start, 1);
    check("mc_c0_pc_en", pc_en, 0);
    cyc(); mc_op_ID = 0;
    @(negedge clk);
    check("mc_w1_state", state, 2);
    check("mc_w1_mc_start", mc_start, 0);
    cyc(); branch_taken_EX = 1;
    @(negedge clk);
    check("mc_w2_ifid_flush", ifid_flush, 0);
    check("mc_w2_pc_en", pc_en, 0);
    cyc(); branch_taken_EX = 0;
    cyc(); mc_done = 1;
    @(negedge clk);
    check("mc_rel_pc_en", pc_en, 1);
    check("mc_rel_idex_bubble", idex_bubble, 0);
    check("mc_rel_mc_error", mc_error, 0);
    cyc(); mc_done = 0;
    @(negedge clk);
    check("mc_after_state", state, 0);
    check("mc_stall_cycles", stall_cycles, 4);

    // Timeout without mc_done, then timeout cycle coinciding with mc_done.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      cyc(); mc_op_ID = 1;
      cyc(); mc_op_ID = 0;
      @(negedge clk);
      check("to_w1_mc_error", mc_error, 0);
      repeat (3) begin
        cyc();
        @(negedge clk);
        check("to_hold_pc_en", pc_en, 0);
      end
      cyc(); mc_done = (pass == 1);
      @(negedge clk);
      check($sformatf("to%0d_w5_mc_error", pass), mc_error, (pass == 0) ? 1 : 0);
      check($sformatf("to%0d_w5_pc_en", pass), pc_en, 1);
      cyc(); mc_done = 0;
      @(negedge clk);
      check($sformatf("to%0d_after_state", pass), state, 0);
      check($sformatf("to%0d_after_mc_error", pass), mc_error, 0);
      check($sformatf("to%0d_stall_cycles", pass), stall_cycles, 5);
    end

    // Reset asserted in the middle of a load stall.
    cyc(); set_load_use();
    cyc(); clear_all();
    @(negedge clk);
    check("rs_mid_state", state, 1);
    cyc(); rst = 1;
    cyc(); rst = 0;
    @(negedge clk);
    check("rs_after_state", state, 0);
    check("rs_after_stall_cycles", stall_cycles, 0);

    // Saturation of the stall counter.
    cyc(); set_load_use();
    repeat (66000) cyc();
    clear_all();
    repeat (4) cyc();
    @(negedge clk);
    check("sat_stall_cycles", stall_cycles, 16'hFFFF);
    check("sat_state", state, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
